// File: rtl/pipelined_barrel_shift.sv
// Pipelined barrel shifter: logical / arithmetic shift and rotate in either
// direction. Sticky output is the OR of every bit discarded by the shift.
// The datapath is an elastic valid/ready pipeline with STAGES register banks.
// Left shifts are done as bit-reverse, right-shift, bit-reverse.
module pipelined_barrel_shift #(
    parameter  int SHAMT_W = 5,
    parameter  int STAGES  = 2,
    localparam int WIDTH   = 1 << SHAMT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_direction,
    input  logic [1:0]         in_mode,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shiftby,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sticky
);
    // One in-flight beat: partial data, shift amount, and decoded op flags
    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        logic               left;    // data is held bit-reversed
        logic               rot;     // rotate: nothing is discarded
        logic               fill;    // bit shifted into the MSBs
        logic               sticky;  // running OR of discarded bits
    } beat_t;

    // First binary level handled by stage s; low levels first, earlier
    // stages take the extra level when SHAMT_W does not divide evenly.
    function automatic int lvl_lo(input int s);
        return s * (SHAMT_W / STAGES) + ((s < SHAMT_W % STAGES) ? s : SHAMT_W % STAGES);
    endfunction

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
        return r;
    endfunction

    beat_t              head;
    beat_t              bank_q  [STAGES];
    beat_t              stg_out [STAGES];
    logic [STAGES-1:0]  vld_q;
    logic [STAGES-1:0]  ld;
    logic [STAGES:0]    vin;
    logic               chain_full;

    // Incoming valid for each bank: in_valid feeds bank 0, bank k-1 feeds bank k
    assign vin = {vld_q, in_valid};

    // Decode the input beat; left shifts are turned into right shifts here
    always_comb begin
        head       = '0;
        head.left  = ~in_direction;
        head.rot   = (in_mode == 2'b10);
        head.fill  = (in_mode == 2'b01) & in_direction & in_data[WIDTH-1];
        head.shamt = in_shiftby;
        head.data  = head.left ? bitrev(in_data) : in_data;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = lvl_lo(s);
        localparam int HI = lvl_lo(s + 1);
        beat_t            src;
        beat_t            cur;
        logic [WIDTH-1:0] lowm;

        if (s == 0) begin : g_head
            assign src = head;
        end else begin : g_bank
            assign src = bank_q[s-1];
        end

        // Apply this stage's binary levels (shift by 2^j) as right shift/rotate
        always_comb begin
            cur  = src;
            lowm = '0;
            for (int j = LO; j < HI; j++) begin
                if (cur.shamt[j]) begin
                    lowm       = ~({WIDTH{1'b1}} << (1 << j));
                    cur.sticky = cur.sticky | (~cur.rot & (|(cur.data & lowm)));
                    if (cur.rot)
                        cur.data = (cur.data >> (1 << j)) | (cur.data << (WIDTH - (1 << j)));
                    else
                        cur.data = (cur.data >> (1 << j))
                                 | ({WIDTH{cur.fill}} & ~({WIDTH{1'b1}} >> (1 << j)));
                end
            end
            if (s == STAGES - 1 && cur.left) cur.data = bitrev(cur.data);
        end

        assign stg_out[s] = cur;
    end

    // A bank loads when it, or any bank after it, is empty, or the output drains
    always_comb begin
        chain_full = 1'b1;
        ld         = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_full = chain_full & vld_q[k];
            ld[k]      = out_ready | ~chain_full;
        end
    end

    // Pipeline banks; data only moves when a real beat arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) bank_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld_q[k] <= vin[k];
                    if (vin[k]) bank_q[k] <= stg_out[k];
                end
            end
        end
    end

    assign in_ready   = ld[0];
    assign out_valid  = vld_q[STAGES-1];
    assign out_data   = bank_q[STAGES-1].data;
    assign out_sticky = bank_q[STAGES-1].sticky;

endmodule

// File: tb/tb_pipelined_barrel_shift.sv
// Self-checking bench for pipelined_barrel_shift: directed vectors, reset
// behaviour, throughput, random backpressure and a parameter sweep, all
// checked against a bit-level reference model of the shift rules.
module tb_pipelined_barrel_shift;
    localparam int SW = 5;
    localparam int ST = 2;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, in_direction;
    logic [1:0]    in_mode;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_shiftby;
    logic          out_valid, out_ready, out_sticky;
    logic [W-1:0]  out_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shift #(.SHAMT_W(SW), .STAGES(ST)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_direction(in_direction),
        .in_mode(in_mode), .in_data(in_data), .in_shiftby(in_shiftby),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sticky(out_sticky)
    );

    // Reference: result bit i takes source bit i+sh (right) or i-sh (left);
    // sticky is the OR of the sh bits that fall off the end.
    function automatic logic [64:0] model(input logic [63:0] d, input int w, input int sh,
                                          input logic dir, input logic [1:0] mode);
        logic [63:0] r;
        logic        st;
        int          src;
        r  = '0;
        st = 1'b0;
        for (int i = 0; i < w; i++) begin
            src = dir ? i + sh : i - sh;
            if (mode == 2'b10)             r[i] = d[(src + w) % w];
            else if (src >= 0 && src < w)  r[i] = d[src];
            else                           r[i] = (mode == 2'b01 && dir) ? d[w-1] : 1'b0;
        end
        if (mode != 2'b10)
            for (int i = 0; i < sh; i++) st = st | (dir ? d[i] : d[w-1-i]);
        return {st, r};
    endfunction

    // Sweep instances over several SHAMT_W / STAGES combinations
    localparam int NC = 6;
    function automatic int csh(input int c);
        case (c)
            0: return 2;
            1: return 3;
            2: return 4;
            3: return 5;
            default: return 6;
        endcase
    endfunction
    function automatic int cst(input int c);
        case (c)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 5;
            4: return 4;
            default: return 6;
        endcase
    endfunction

    logic        sw_iv [NC];
    logic        sw_ir [NC];
    logic        sw_dir[NC];
    logic        sw_ov [NC];
    logic        sw_or [NC];
    logic        sw_st [NC];
    logic [1:0]  sw_mode[NC];
    logic [63:0] sw_din [NC];
    logic [63:0] sw_dout[NC];
    logic [5:0]  sw_sh  [NC];

    for (genvar g = 0; g < NC; g++) begin : g_sw
        localparam int GS = csh(g);
        localparam int GW = 1 << GS;
        logic [GW-1:0] din, od;
        logic [GS-1:0] sh;
        assign din        = sw_din[g][GW-1:0];
        assign sh         = sw_sh[g][GS-1:0];
        assign sw_dout[g] = 64'(od);
        pipelined_barrel_shift #(.SHAMT_W(GS), .STAGES(cst(g))) u_sw (
            .clk(clk), .reset_n(reset_n),
            .in_valid(sw_iv[g]), .in_ready(sw_ir[g]), .in_direction(sw_dir[g]),
            .in_mode(sw_mode[g]), .in_data(din), .in_shiftby(sh),
            .out_valid(sw_ov[g]), .out_ready(sw_or[g]),
            .out_data(od), .out_sticky(sw_st[g])
        );
    end

    task automatic drive_random();
        in_direction = 1'($urandom);
        in_mode      = 2'($urandom);
        in_data      = $urandom;
        in_shiftby   = SW'($urandom);
    endtask

    function automatic logic [32:0] expect_cur();
        logic [64:0] e;
        e = model(64'(in_data), W, int'(in_shiftby), in_direction, in_mode);
        return {e[64], e[31:0]};
    endfunction

    // Single beat through an idle pipeline; returns result and latency in edges
    task automatic run_one(input logic dir, input logic [1:0] mode, input logic [W-1:0] d,
                           input logic [SW-1:0] sh, output logic [W-1:0] od,
                           output logic os, output int lat);
        in_valid = 1'b1; in_direction = dir; in_mode = mode; in_data = d; in_shiftby = sh;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        od = out_data;
        os = out_sticky;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_direction = 1'b0; in_mode = 2'b00; in_data = '0; in_shiftby = '0;
        for (int c = 0; c < NC; c++) begin
            sw_iv[c] = 1'b0; sw_or[c] = 1'b1; sw_dir[c] = 1'b0;
            sw_mode[c] = 2'b00; sw_din[c] = '0; sw_sh[c] = '0;
        end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_out_sticky: got %b want 0", out_sticky); end
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        dir;
        logic [1:0]  mode;
        logic [31:0] d;
        int          sh;
        logic [31:0] e;
        logic        es;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl[9];
        logic [31:0] od;
        logic        os;
        int          lat;
        tbl[0] = '{1'b1, 2'b01, 32'h80000010, 4,  32'hF8000001, 1'b0};
        tbl[1] = '{1'b1, 2'b00, 32'h80000010, 4,  32'h08000001, 1'b0};
        tbl[2] = '{1'b1, 2'b00, 32'h0000000F, 2,  32'h00000003, 1'b1};
        tbl[3] = '{1'b0, 2'b00, 32'hC0000001, 1,  32'h80000002, 1'b1};
        tbl[4] = '{1'b0, 2'b10, 32'hC0000001, 1,  32'h80000003, 1'b0};
        tbl[5] = '{1'b1, 2'b10, 32'h00000001, 31, 32'h00000002, 1'b0};
        tbl[6] = '{1'b0, 2'b11, 32'hC0000001, 1,  32'h80000002, 1'b1};
        tbl[7] = '{1'b0, 2'b01, 32'hC0000001, 1,  32'h80000002, 1'b1};
        tbl[8] = '{1'b1, 2'b01, 32'h80000001, 0,  32'h80000001, 1'b0};
        for (int i = 0; i < 9; i++) begin
            run_one(tbl[i].dir, tbl[i].mode, tbl[i].d, tbl[i].sh[SW-1:0], od, os, lat);
            n_cmp++;
            if (od !== tbl[i].e || os !== tbl[i].es || lat != ST) begin
                n_bad++;
                $display("FAIL directed[%0d]: got data=%h sticky=%b lat=%0d want data=%h sticky=%b lat=%0d",
                         i, od, os, lat, tbl[i].e, tbl[i].es, ST);
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_random();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midreset_inflight: out_valid got %b want 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_sticky !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: got valid=%b ready=%b data=%h sticky=%b want 0 1 0 0",
                     out_valid, in_ready, out_data, out_sticky);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_quiet[%0d]: out_valid got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] q[$];
        int          first;
        int          nout;
        first = -1;
        nout  = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 106; cyc++) begin
            if (cyc < 100) begin drive_random(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #3;
            if (cyc < 100) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready); end
                q.push_back(expect_cur());
            end
            if (cyc >= 2 && cyc < 102) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_gap[%0d]: out_valid got %b want 1", cyc, out_valid); end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                nout++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra[%0d]: got %h with nothing outstanding", cyc, out_data);
                end else begin
                    if ({out_sticky, out_data} !== q[0]) begin
                        n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", cyc, {out_sticky, out_data}, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (first != 2 || nout != 100) begin
            n_bad++; $display("FAIL b2b_timing: first=%0d count=%0d want first=2 count=100", first, nout);
        end
    endtask

    task automatic test_backpressure();
        localparam int N = 10000;
        logic [32:0] q[$];
        logic [32:0] held;
        logic        stalled;
        int          sent, got, cyc;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < N && cyc < 60000) begin
            drive_random();
            in_valid  = (sent < N) && ($urandom_range(3) != 0);
            out_ready = (sent >= N) ? 1'b1 : 1'($urandom);
            #3;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {out_sticky, out_data} !== held) begin
                    n_bad++; $display("FAIL bp_stall_hold[%0d]: got valid=%b %h want valid=1 %h",
                                      cyc, out_valid, {out_sticky, out_data}, held);
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(expect_cur());
                sent++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra[%0d]: got %h with nothing outstanding", cyc, out_data);
                end else begin
                    if ({out_sticky, out_data} !== q[0]) begin
                        n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", got, {out_sticky, out_data}, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held    = {out_sticky, out_data};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != N || sent != N || q.size() != 0) begin
            n_bad++; $display("FAIL bp_totals: sent=%0d got=%0d left=%0d want %0d %0d 0", sent, got, q.size(), N, N);
        end
    endtask

    task automatic test_sweep();
        for (int c = 0; c < NC; c++) begin
            for (int m = 0; m < 4; m++) begin
                for (int dr = 0; dr < 2; dr++) begin
                    for (int k = 0; k < 2; k++) begin
                        logic [63:0] d;
                        logic [64:0] e;
                        int          w, sh, lat;
                        w = 1 << csh(c);
                        d = {$urandom, $urandom};
                        if (w < 64) d = d & ((64'd1 << w) - 64'd1);
                        sh = (k != 0) ? w - 1 : 0;
                        sw_din[c] = d; sw_sh[c] = 6'(sh); sw_dir[c] = dr[0]; sw_mode[c] = m[1:0];
                        sw_iv[c] = 1'b1; sw_or[c] = 1'b1;
                        @(posedge clk); #1;
                        sw_iv[c] = 1'b0;
                        lat = 1;
                        while (!sw_ov[c] && lat < 20) begin
                            @(posedge clk); #1;
                            lat++;
                        end
                        e = model(d, w, sh, dr[0], m[1:0]);
                        n_cmp++;
                        if (lat != cst(c) || sw_dout[c] !== e[63:0] || sw_st[c] !== e[64]) begin
                            n_bad++;
                            $display("FAIL sweep[w=%0d st=%0d mode=%0d dir=%0d sh=%0d]: got data=%h sticky=%b lat=%0d want data=%h sticky=%b lat=%0d",
                                     w, cst(c), m, dr, sh, sw_dout[c], sw_st[c], lat, e[63:0], e[64], cst(c));
                        end
                        @(posedge clk); #1;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_midstream();
        test_back_to_back();
        test_backpressure();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
